// File: rtl/lpif_pipe_reader_if.sv
// ---------------------------------------------------------------------------
// lpif_pipe_reader_if
//   Bundles the two handshakes of the LPIF pipe reader:
//     upstream   : in_empty / in_rddata (from buffer), in_pop (to buffer)
//     downstream : out_valid / out_data / out_last (to sink), out_ready (from sink)
//   Modports:
//     master : the reader itself (pops upstream, drives the chunk stream)
//     slave  : the environment (upstream buffer plus downstream sink)
//   OUT_WIDTH is derived from DATA_WIDTH and RATIO and cannot be overridden.
// ---------------------------------------------------------------------------
interface lpif_pipe_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int RATIO      = 4
);
    localparam int OUT_WIDTH = DATA_WIDTH / RATIO;

    logic                  in_empty;
    logic [DATA_WIDTH-1:0] in_rddata;
    logic                  in_pop;

    logic                  out_valid;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_last;
    logic                  out_ready;

    modport master (
        input  in_empty,
        input  in_rddata,
        output in_pop,
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        output in_empty,
        output in_rddata,
        input  in_pop,
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/lpif_pipe_reader.sv
// ---------------------------------------------------------------------------
// lpif_pipe_reader
//   Drains words from an upstream push/pop buffer into a local hold register
//   and replays each word downstream as RATIO LSB-first chunks of
//   DATA_WIDTH/RATIO bits on a valid/ready interface.
//
//   Ports:
//     lclk       : clock, rising edge
//     reset      : asynchronous, active-low reset
//     bus        : lpif_pipe_reader_if.master (upstream empty/rddata/pop,
//                  downstream valid/data/last/ready)
//     drain_en   : gate for new pops; a word already held always completes
//     busy       : hold register occupied (same as out_valid)
//     words_done : count of fully delivered words, wraps at 16 bits
//
//   The next word is popped in the same cycle the last chunk of the current
//   word is accepted, so a continuously fed stream has no bubbles.
// ---------------------------------------------------------------------------
module lpif_pipe_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int RATIO      = 4
) (
    input  logic                  lclk,
    input  logic                  reset,
    lpif_pipe_reader_if.master    bus,
    input  logic                  drain_en,
    output logic                  busy,
    output logic [15:0]           words_done
);
    localparam int OUT_WIDTH = DATA_WIDTH / RATIO;
    // One index bit is kept even for RATIO=1; it then never leaves zero
    // because every chunk is the last one.
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [15:0]           words_done_reg;

    logic hold_valid;
    logic last_chunk;
    logic acc;
    logic lacc;
    logic pop;

    assign hold_valid = (state_reg == SEND);
    assign last_chunk = hold_valid & (idx_reg == IDX_LAST);
    assign acc        = hold_valid & bus.out_ready;
    assign lacc       = acc & last_chunk;

    // Reset term keeps the strobe low during reset so the upstream buffer
    // never loses a word that this block is about to discard.
    assign pop = reset & ~bus.in_empty & drain_en & (~hold_valid | lacc);

    always_ff @(posedge lclk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            hold_reg       <= '0;
            idx_reg        <= '0;
            words_done_reg <= '0;
        end else begin
            if (pop) begin
                // Covers both IDLE->SEND and a back-to-back SEND->SEND reload.
                hold_reg  <= bus.in_rddata;
                state_reg <= SEND;
                idx_reg   <= '0;
            end else if (lacc) begin
                // hold_reg deliberately keeps the old word.
                state_reg <= IDLE;
                idx_reg   <= '0;
            end else if (acc) begin
                idx_reg <= idx_reg + IDX_W'(1);
            end

            if (lacc) begin
                words_done_reg <= words_done_reg + 16'd1;
            end
        end
    end

    // Chunk select: slice the hold register into RATIO lanes, index by idx.
    generate
        if (RATIO == 1) begin : g_single
            assign bus.out_data = hold_reg;
        end else begin : g_multi
            logic [OUT_WIDTH-1:0] chunk [RATIO];
            for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
                assign chunk[gi] = hold_reg[gi*OUT_WIDTH +: OUT_WIDTH];
            end
            assign bus.out_data = chunk[idx_reg];
        end
    endgenerate

    assign bus.in_pop    = pop;
    assign bus.out_valid = hold_valid;
    assign bus.out_last  = last_chunk;
    assign busy          = hold_valid;
    assign words_done    = words_done_reg;

endmodule

// File: tb/tb_lpif_pipe_reader.sv
// ---------------------------------------------------------------------------
// tb_lpif_pipe_reader
//   Two readers share clock, reset and drain_en: one with RATIO=4 (byte
//   chunks of a 32-bit word) and one with RATIO=1 (used for the counter wrap).
//   Each has a queue-modelled upstream buffer; every pushed word also pushes
//   its expected chunks into a scoreboard queue that is popped on accepts.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lpif_pipe_reader;
    logic        lclk = 1'b0;
    logic        reset;
    logic        drain_en;
    logic        busy4, busy1;
    logic [15:0] wd4, wd1;

    always #5 lclk = ~lclk;

    lpif_pipe_reader_if #(.DATA_WIDTH(32), .RATIO(4)) bus4 ();
    lpif_pipe_reader_if #(.DATA_WIDTH(32), .RATIO(1)) bus1 ();

    lpif_pipe_reader #(.DATA_WIDTH(32), .RATIO(4)) u_dut4 (
        .lclk       (lclk),
        .reset      (reset),
        .bus        (bus4.master),
        .drain_en   (drain_en),
        .busy       (busy4),
        .words_done (wd4)
    );

    lpif_pipe_reader #(.DATA_WIDTH(32), .RATIO(1)) u_dut1 (
        .lclk       (lclk),
        .reset      (reset),
        .bus        (bus1.master),
        .drain_en   (drain_en),
        .busy       (busy1),
        .words_done (wd1)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
    } chunk4_t;

    chunk4_t     exp4_q[$];
    logic [31:0] exp1_q[$];
    logic [31:0] up4_q[$];
    logic [31:0] up1_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int pops4    = 0;

    logic       s_pop4, s_valid4, s_last4, s_acc4;
    logic [7:0] s_data4;
    logic       s_pop1, s_valid1, s_last1, s_acc1;
    logic [31:0] s_data1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive_up();
        bus4.in_empty  = (up4_q.size() == 0);
        bus4.in_rddata = (up4_q.size() == 0) ? 32'h0 : up4_q[0];
        bus1.in_empty  = (up1_q.size() == 0);
        bus1.in_rddata = (up1_q.size() == 0) ? 32'h0 : up1_q[0];
    endtask

    task automatic push4(input logic [31:0] w);
        up4_q.push_back(w);
        for (int i = 0; i < 4; i++) begin
            exp4_q.push_back('{w[i*8 +: 8], (i == 3)});
        end
        drive_up();
    endtask

    task automatic push1(input logic [31:0] w);
        up1_q.push_back(w);
        exp1_q.push_back(w);
        drive_up();
    endtask

    // One clock cycle: sample just after the falling edge (inputs are stable
    // until the rising edge), score accepts, then advance the upstream model.
    task automatic tick();
        chunk4_t     e4;
        logic [31:0] e1;
        #1;
        s_pop4   = bus4.in_pop;
        s_valid4 = bus4.out_valid;
        s_data4  = bus4.out_data;
        s_last4  = bus4.out_last;
        s_acc4   = bus4.out_valid & bus4.out_ready;
        s_pop1   = bus1.in_pop;
        s_valid1 = bus1.out_valid;
        s_data1  = bus1.out_data;
        s_last1  = bus1.out_last;
        s_acc1   = bus1.out_valid & bus1.out_ready;

        check_val("busy4_is_valid", busy4, s_valid4);
        if (s_pop4) pops4++;
        if (s_pop4 && s_valid4)
            check_val("pop4_only_at_last_accept", s_acc4 & s_last4, 1);

        if (s_acc4) begin
            check_val("sb4_has_entry", exp4_q.size() != 0, 1);
            if (exp4_q.size() != 0) begin
                e4 = exp4_q.pop_front();
                $display("u4 chunk data=0x%02h last=%0b words_done=%0d", s_data4, s_last4, wd4);
                check_val("sb4_data", s_data4, e4.data);
                check_val("sb4_last", s_last4, e4.last);
            end
        end

        if (s_acc1) begin
            check_val("sb1_has_entry", exp1_q.size() != 0, 1);
            if (exp1_q.size() != 0) begin
                e1 = exp1_q.pop_front();
                if (wd1 < 16'd3 || wd1 > 16'hFFFC)
                    $display("u1 word data=0x%08h last=%0b words_done=%0d", s_data1, s_last1, wd1);
                check_val("sb1_data", s_data1, e1);
                check_val("sb1_last", s_last1, 1);
            end
            if (!bus1.in_empty && drain_en)
                check_val("pop1_on_every_accept", s_pop1, 1);
        end

        @(posedge lclk);
        if (s_pop4) up4_q.delete(0);
        if (s_pop1) up1_q.delete(0);
        @(negedge lclk);
        drive_up();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic l;
        reset          = 1'b0;
        drain_en       = 1'b1;
        bus4.out_ready = 1'b1;
        bus1.out_ready = 1'b1;
        drive_up();
        @(negedge lclk);

        // Reset state; a word is already waiting upstream but must not be popped.
        push4(32'hDDCCBBAA);
        tick();
        check_val("rst_in_pop", s_pop4, 0);
        check_val("rst_out_valid", s_valid4, 0);
        check_val("rst_out_last", s_last4, 0);
        check_val("rst_out_data", s_data4, 0);
        check_val("rst_busy", busy4, 0);
        check_val("rst_words_done4", wd4, 0);
        check_val("rst_words_done1", wd1, 0);

        // Single word: pop on the first edge after release, then 4 chunks.
        reset = 1'b1;
        pops4 = 0;
        tick();
        check_val("t1_pop_on_release", s_pop4, 1);
        check_val("t1_not_valid_yet", s_valid4, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("t1_valid_run", s_valid4, 1);
        end
        tick();
        check_val("t1_idle", s_valid4, 0);
        check_val("t1_pop_count", pops4, 1);
        check_val("t1_words_done", wd4, 1);

        // Back-to-back: 8 valid cycles, second pop at the last accept of word 1.
        pops4 = 0;
        push4(32'h11111111);
        push4(32'h22222222);
        tick();
        check_val("t2_first_pop", s_pop4, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_val("t2_no_gap", s_valid4, 1);
            if (i == 3) begin
                check_val("t2_second_pop_at_lacc", s_pop4 & s_acc4 & s_last4, 1);
                check_val("t2_lacc_data", s_data4, 8'h11);
            end
        end
        tick();
        check_val("t2_idle", s_valid4, 0);
        check_val("t2_pop_count", pops4, 2);
        check_val("t2_words_done", wd4, 3);

        // Backpressure on chunk 1 with another word waiting upstream.
        push4(32'hDDCCBBAA);
        push4(32'h55667788);
        tick();
        check_val("t3_pop", s_pop4, 1);
        tick();
        bus4.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("t3_hold_valid", s_valid4, 1);
            check_val("t3_hold_data", s_data4, 8'hBB);
            check_val("t3_no_pop", s_pop4, 0);
        end
        bus4.out_ready = 1'b1;
        tick();
        check_val("t3_resume_accept", s_acc4, 1);
        check_val("t3_resume_data", s_data4, 8'hBB);
        for (int i = 0; i < 6; i++) tick();
        tick();
        check_val("t3_idle", s_valid4, 0);
        check_val("t3_words_done", wd4, 5);

        // drain_en dropped after chunk 0 of word A; word B waits upstream.
        push4(32'hA3A2A1A0);
        push4(32'hB3B2B1B0);
        tick();
        tick();
        drain_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("t4_word_a_drains", s_valid4, 1);
            check_val("t4_no_pop_mid", s_pop4, 0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("t4_idle", s_valid4, 0);
            check_val("t4_no_pop_idle", s_pop4, 0);
        end
        check_val("t4_words_done_a", wd4, 6);
        drain_en = 1'b1;
        tick();
        check_val("t4_pop_on_enable", s_pop4, 1);
        for (int i = 0; i < 4; i++) tick();
        tick();
        check_val("t4_idle_after_b", s_valid4, 0);
        check_val("t4_words_done_b", wd4, 7);

        // Reset after chunk 1 accepted: outputs clear without a clock edge.
        push4(32'hC3C2C1C0);
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_val("t5_valid_cleared", bus4.out_valid, 0);
        check_val("t5_data_cleared", bus4.out_data, 0);
        check_val("t5_words_done_cleared", wd4, 0);
        check_val("t5_busy_cleared", busy4, 0);
        while (exp4_q.size() > 0) begin
            l = exp4_q[0].last;
            exp4_q.delete(0);
            if (l) break;
        end
        tick();
        check_val("t5_no_pop_in_reset", s_pop4, 0);
        reset = 1'b1;
        push4(32'hD3D2D1D0);
        tick();
        check_val("t5_pop_after_release", s_pop4, 1);
        tick();
        check_val("t5_restart_valid", s_valid4, 1);
        check_val("t5_restart_chunk0", s_data4, 8'hD0);
        for (int i = 0; i < 3; i++) tick();
        tick();
        check_val("t5_idle", s_valid4, 0);
        check_val("t5_words_done", wd4, 1);

        // RATIO=1: 0xFFFF one-chunk words streamed without gaps, then wrap.
        for (int i = 0; i < 65535; i++) push1(32'(i) * 32'h9E3779B9);
        for (int i = 0; i < 65536; i++) tick();
        check_val("t6_words_done_ffff", wd1, 16'hFFFF);
        check_val("t6_busy_after_stream", busy1, 0);
        check_val("t6_sb1_drained", exp1_q.size(), 0);
        push1(32'h12345678);
        tick();
        check_val("t6_pop", s_pop1, 1);
        tick();
        check_val("t6_valid", s_valid1, 1);
        check_val("t6_last", s_last1, 1);
        tick();
        check_val("t6_words_done_wrap", wd1, 16'h0000);
        check_val("t6_other_counter_untouched", wd4, 1);

        check_val("end_sb4_empty", exp4_q.size(), 0);
        check_val("end_sb1_empty", exp1_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lpif_pipe_reader.md
# lpif_pipe_reader

Reader-side companion to the LPIF single-entry pipeline buffer. It drains words from an upstream buffer's empty/rddata/pop port, holds each word in a local register, and emits it to a narrower downstream valid/ready interface as RATIO LSB-first chunks. It is the consumer end of the push/pop buffer protocol and runs in the same clock domain as the buffer it drains.

## Interface
- DATA_WIDTH, 32, width of the upstream word
- RATIO, 4, chunks per word; a power of two, 1 to 16, and DATA_WIDTH divisible by RATIO
- OUT_WIDTH, derived (DATA_WIDTH/RATIO), width of one chunk; not overridable
- lclk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- in_empty  input  1  upstream buffer empty flag (registered upstream)
- in_rddata  input  DATA_WIDTH  upstream buffer data; valid when in_empty=0
- in_pop  output  1  pop strobe to upstream; combinational
- drain_en  input  1  when 0, no new words are popped; the word in flight still completes
- out_valid  output  1  chunk valid
- out_data  output  OUT_WIDTH  current chunk
- out_last  output  1  current chunk is the final chunk of its word
- out_ready  input  1  downstream accepts the chunk when out_valid & out_ready
- busy  output  1  hold register occupied (equals out_valid)
- words_done  output  16  count of fully delivered words; wraps

## Operation
- State: hold register (DATA_WIDTH), hold_valid, chunk index idx (log2 RATIO bits; 1 bit when RATIO=1, tied 0), and words_done.
- Two states:
  - IDLE (hold_valid=0).
  - SEND (hold_valid=1).
- Accept: acc = out_valid & out_ready. Last accept: lacc = acc & out_last.
- in_pop = ~in_empty & drain_en & (~hold_valid | lacc). It is forced 0 while reset is low.
- On in_pop: hold <= in_rddata, hold_valid <= 1, idx <= 0. This covers IDLE→SEND, and SEND→SEND on a back-to-back word.
- On lacc without in_pop: hold_valid <= 0 (SEND→IDLE), idx <= 0. The hold data register keeps its value.
- On acc with out_last=0: idx <= idx+1.
- out_valid = hold_valid.
- out_data = hold[idx*OUT_WIDTH +: OUT_WIDTH].
- out_last = hold_valid & (idx == RATIO-1). When RATIO=1, every chunk is last.
- words_done increments by 1 on each lacc and wraps from 0xFFFF to 0x0000.
- out_data is stable while out_valid=1 and out_ready=0. The chunk must not change until it is accepted.
- drain_en deasserted mid-word: the remaining chunks still drain; once the last chunk is accepted, the block goes to IDLE.
- in_empty=1 at lacc: the block goes to IDLE. No pop is issued.
- Upstream buffer push and in_pop in the same cycle is legal. The upstream stays non-empty with new data, which the next pop takes.

## Timing
- Reset values:
  - out_valid=0, out_last=0, busy=0, in_pop=0
  - out_data=0 (hold resets to all zeros)
  - idx=0, words_done=0
- Pop-to-output latency: pop in cycle N gives out_valid=1 with chunk 0 in cycle N+1.
- Throughput: with out_ready=1 and upstream never empty, one chunk per cycle. Word k+1 is popped in the same cycle that word k's last chunk is accepted, so there are no bubbles.
- Pop timing by state:
  - In IDLE, in_pop rises in the same cycle in_empty falls, provided drain_en=1.
  - In SEND, in_pop is asserted only in the cycle of the last-chunk accept.
- Reset asserted mid-word: hold_valid, idx and words_done clear immediately (asynchronously). The partial word is discarded and no further chunk is presented.
- Release of reset: first possible pop is the first rising edge after reset goes high, with in_empty=0.

## Test plan
- **Single word.** DATA_WIDTH=32, RATIO=4, out_ready=1; push 0xDDCCBBAA upstream. Required:
  - one in_pop pulse
  - out_data 0xAA, 0xBB, 0xCC, 0xDD on four consecutive cycles, out_last on 0xDD only
  - words_done=1, then IDLE
- **Back-to-back.** Upstream holds 0x11111111 then 0x22222222, out_ready=1. Required:
  - 8 consecutive valid cycles with no gap
  - second in_pop coincides with the accept of chunk 0x11 with out_last=1
  - words_done=2
- **Backpressure.** out_ready=0 for 5 cycles after chunk 1 is presented. Required:
  - out_data holds 0xBB and out_valid stays 1
  - idx does not advance and in_pop=0
  - the stream resumes on out_ready=1
- **drain_en drop.** Deassert drain_en after chunk 0 of word A, with word B waiting upstream. Required:
  - word A completes, then IDLE
  - in_empty stays 0 and no pop occurs until drain_en=1
- **Reset mid-word.** Assert reset after chunk 1 is accepted. Required:
  - out_valid=0, out_data=0, words_done=0 immediately
  - after release, the next pushed word starts at chunk 0
- **Wrap and RATIO=1.** Preload 0xFFFF words; the next word sets words_done=0x0000. With RATIO=1, each word is one chunk with out_last=1 and a pop on every accept.
